// File: rtl/lsu_mem_responder.sv
// Load/store unit front end: turns memory-stage controls into a single
// valid/ready word access, formats store lanes and load results, stalls
// the pipeline while the access is in flight, and reports misaligned,
// illegal and timed-out accesses for exactly one cycle in DONE.
module lsu_mem_responder #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mem_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_cause,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] MT_B  = 3'd0;
    localparam logic [2:0] MT_H  = 3'd1;
    localparam logic [2:0] MT_W  = 3'd2;
    localparam logic [2:0] MT_BU = 3'd3;
    localparam logic [2:0] MT_HU = 3'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // Last counter value allowed before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [2:0]  mt_reg, mt_next;
    logic [1:0]  off_reg, off_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;
    logic [1:0]  cause_reg, cause_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  be_reg, be_next;
    logic        stall_c;

    logic        illegal;
    logic        misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode the incoming request: legality, alignment and store lane layout.
    always_comb begin
        illegal    = wr_en ? (mem_type >= 3'd3) : (mem_type >= 3'd5);
        misaligned = 1'b0;
        st_wdata   = 32'd0;
        st_be      = 4'b0000;
        case (mem_type)
            MT_H, MT_HU: misaligned = addr[0];
            MT_W:        misaligned = (addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        if (wr_en) begin
            case (mem_type)
                MT_B: begin
                    st_wdata = {4{wdata[7:0]}};
                    st_be    = 4'b0001 << addr[1:0];
                end
                MT_H: begin
                    st_wdata = {2{wdata[15:0]}};
                    st_be    = addr[1] ? 4'b1100 : 4'b0011;
                end
                MT_W: begin
                    st_wdata = wdata;
                    st_be    = 4'b1111;
                end
                default: begin
                    st_wdata = 32'd0;
                    st_be    = 4'b0000;
                end
            endcase
        end
    end

    // Pick the addressed lane of the returned word and extend it.
    always_comb begin
        ld_byte = bus_rdata[{off_reg, 3'b000} +: 8];
        ld_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (mt_reg)
            MT_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            MT_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            MT_BU:   ld_data = {24'd0, ld_byte};
            MT_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    // Next-state and output logic; err/err_cause fall back to zero outside DONE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mt_next    = mt_reg;
        off_next   = off_reg;
        rdata_next = rdata_reg;
        err_next   = 1'b0;
        cause_next = CAUSE_NONE;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        stall_c    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                stall_c = rd_en | wr_en;
                if (rd_en | wr_en) begin
                    if (illegal) begin
                        state_next = S_DONE;
                        err_next   = 1'b1;
                        cause_next = CAUSE_ILLEGAL;
                    end else if (misaligned) begin
                        state_next = S_DONE;
                        err_next   = 1'b1;
                        cause_next = CAUSE_MISALIGN;
                    end else begin
                        state_next = S_REQ;
                        cnt_next   = 8'd0;
                        we_next    = wr_en;
                        addr_next  = {addr[31:2], 2'b00};
                        wdata_next = st_wdata;
                        be_next    = st_be;
                        mt_next    = mem_type;
                        off_next   = addr[1:0];
                    end
                end
            end
            S_REQ, S_WAIT: begin
                stall_c = 1'b1;
                if ((state_reg == S_REQ) && bus_ready && we_reg) begin
                    state_next = S_DONE;
                end else if ((state_reg == S_WAIT) && bus_rvalid) begin
                    state_next = S_DONE;
                    rdata_next = ld_data;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_DONE;
                    err_next   = 1'b1;
                    cause_next = CAUSE_TIMEOUT;
                    rdata_next = 32'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                    if ((state_reg == S_REQ) && bus_ready) begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 8'd0;
            mt_reg    <= 3'd0;
            off_reg   <= 2'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
            cause_reg <= CAUSE_NONE;
            we_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            be_reg    <= 4'b0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mt_reg    <= mt_next;
            off_reg   <= off_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            cause_reg <= cause_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
        end
    end

    assign stall     = stall_c;
    assign rdata     = rdata_reg;
    assign err       = err_reg;
    assign err_cause = cause_reg;
    assign bus_valid = (state_reg == S_REQ);
    assign bus_we    = we_reg;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign bus_be    = be_reg;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder. Stimulus pushes expected bus
// requests and DONE results; a negedge monitor compares them as the DUT
// presents them. A second instance with a short timeout covers the abort path.
module tb_lsu_mem_responder;
    localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2, BU = 3'd3, HU = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd_en = 1'b0, wr_en = 1'b0, use_b = 1'b0;
    logic [2:0]  mem_type = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    logic        rd_a, wr_a, rd_b, wr_b;
    assign rd_a = rd_en & ~use_b;
    assign wr_a = wr_en & ~use_b;
    assign rd_b = rd_en & use_b;
    assign wr_b = wr_en & use_b;

    logic        a_stall, a_err, a_valid, a_we, b_stall, b_err, b_valid, b_we;
    logic [1:0]  a_cause, b_cause;
    logic [31:0] a_rdata, a_addr, a_wdata, b_rdata, b_addr, b_wdata;
    logic [3:0]  a_be, b_be;

    lsu_mem_responder #(.TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_a), .wr_en(wr_a), .mem_type(mem_type),
        .addr(addr), .wdata(wdata), .stall(a_stall), .rdata(a_rdata), .err(a_err),
        .err_cause(a_cause), .bus_valid(a_valid), .bus_we(a_we), .bus_addr(a_addr),
        .bus_wdata(a_wdata), .bus_be(a_be), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    lsu_mem_responder #(.TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_b), .wr_en(wr_b), .mem_type(mem_type),
        .addr(addr), .wdata(wdata), .stall(b_stall), .rdata(b_rdata), .err(b_err),
        .err_cause(b_cause), .bus_valid(b_valid), .bus_we(b_we), .bus_addr(b_addr),
        .bus_wdata(b_wdata), .bus_be(b_be), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    logic        m_stall, m_err, m_valid, m_we;
    logic [1:0]  m_cause;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;
    assign m_stall = use_b ? b_stall : a_stall;
    assign m_err   = use_b ? b_err   : a_err;
    assign m_valid = use_b ? b_valid : a_valid;
    assign m_we    = use_b ? b_we    : a_we;
    assign m_cause = use_b ? b_cause : a_cause;
    assign m_rdata = use_b ? b_rdata : a_rdata;
    assign m_addr  = use_b ? b_addr  : a_addr;
    assign m_wdata = use_b ? b_wdata : a_wdata;
    assign m_be    = use_b ? b_be    : a_be;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        err;
        logic [1:0]  cause;
        int          stalls;
    } done_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [3:0]  be;
    } bus_t;

    done_t sb_done[$];
    bus_t  sb_bus[$];
    int    checks = 0;
    int    errors = 0;
    int    txn = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Bus responder configuration.
    int          ready_delay = 0;
    logic        never_ready = 1'b0, never_rvalid = 1'b0, stray = 1'b0;
    logic [31:0] rd_word = 32'd0;
    int          vcnt = 0;
    logic        pv = 1'b0, pr = 1'b0, pwe = 1'b0;

    // Slave model: ready after ready_delay valid cycles, rvalid the cycle after a load handshake.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            bus_ready = 1'b0; bus_rvalid = 1'b0; vcnt = 0; pv = 1'b0; pr = 1'b0; pwe = 1'b0;
        end else begin
            bus_rvalid = pv && pr && !pwe && !never_rvalid;
            bus_rdata  = bus_rvalid ? rd_word : 32'hDEADBEEF;
            if (m_valid) begin
                bus_ready = !never_ready && (vcnt >= ready_delay);
                vcnt++;
            end else begin
                bus_ready = 1'b0;
                vcnt = 0;
            end
            if (stray && bus_ready && !m_we) bus_rvalid = 1'b1;
            pv = m_valid; pr = bus_ready; pwe = m_we;
        end
    end

    // Monitor: compares bus requests while valid and results on the DONE cycle.
    int    scnt = 0;
    logic  prev_stall = 1'b0;
    bus_t  be_e;
    done_t dn_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            scnt = 0;
        end else begin
            if (m_valid) begin
                if (sb_bus.size() == 0) begin
                    chk("bus_valid_unexpected", {31'd0, m_valid}, 32'd0);
                end else begin
                    be_e = sb_bus[0];
                    chk("bus_we", {31'd0, m_we}, {31'd0, be_e.we});
                    chk("bus_addr", m_addr, be_e.addr);
                    if (be_e.chk_wdata) chk("bus_wdata", m_wdata, be_e.wdata);
                    chk("bus_be", {28'd0, m_be}, {28'd0, be_e.be});
                    if (bus_ready) void'(sb_bus.pop_front());
                end
            end
            if (m_stall) scnt++;
            if (prev_stall && !m_stall) begin
                if (sb_done.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    dn_e = sb_done.pop_front();
                    txn++;
                    chk("err", {31'd0, m_err}, {31'd0, dn_e.err});
                    chk("err_cause", {30'd0, m_cause}, {30'd0, dn_e.cause});
                    if (dn_e.chk_rdata) chk("rdata", m_rdata, dn_e.rdata);
                    if (dn_e.stalls >= 0) chk("stall_cycles", scnt, dn_e.stalls);
                    chk("done_bus_valid", {31'd0, m_valid}, 32'd0);
                    $display("txn %0d: dut=%s err=%0b cause=%0d rdata=0x%08h stalls=%0d",
                             txn, use_b ? "b" : "a", m_err, m_cause, m_rdata, scnt);
                end
                scnt = 0;
            end
            prev_stall = m_stall;
        end
    end

    task automatic exp_bus(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic chkd, input logic [3:0] be);
        bus_t e;
        e.we = we; e.addr = a; e.wdata = d; e.chk_wdata = chkd; e.be = be;
        sb_bus.push_back(e);
    endtask

    task automatic exp_done(input logic [31:0] rd, input logic chkr, input logic e_err,
                            input logic [1:0] cause, input int stalls);
        done_t e;
        e.rdata = rd; e.chk_rdata = chkr; e.err = e_err; e.cause = cause; e.stalls = stalls;
        sb_done.push_back(e);
    endtask

    // Hold the request until stall drops (the DONE cycle), then release it.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] mt,
                         input logic [31:0] a, input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        rd_en = rd; wr_en = wr; mem_type = mt; addr = a; wdata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!m_stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("completion_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_stall"}, {31'd0, m_stall}, 32'd0);
        chk({tag, "_err"}, {31'd0, m_err}, 32'd0);
        chk({tag, "_cause"}, {30'd0, m_cause}, 32'd0);
        chk({tag, "_rdata"}, m_rdata, 32'd0);
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_we"}, {31'd0, m_we}, 32'd0);
        chk({tag, "_addr"}, m_addr, 32'd0);
        chk({tag, "_wdata"}, m_wdata, 32'd0);
        chk({tag, "_be"}, {28'd0, m_be}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Stores: byte, half, word
        exp_bus(1'b1, 32'h100, 32'hA5A5A5A5, 1'b1, 4'b1000);
        exp_done(32'd0, 1'b0, 1'b0, 2'b00, 2);
        issue(1'b0, 1'b1, B, 32'h103, 32'h000000A5);
        exp_bus(1'b1, 32'h100, 32'hBEEFBEEF, 1'b1, 4'b1100);
        exp_done(32'd0, 1'b0, 1'b0, 2'b00, 2);
        issue(1'b0, 1'b1, H, 32'h102, 32'h1234BEEF);
        exp_bus(1'b1, 32'h108, 32'h89ABCDEF, 1'b1, 4'b1111);
        exp_done(32'd0, 1'b0, 1'b0, 2'b00, 2);
        issue(1'b0, 1'b1, W, 32'h108, 32'h89ABCDEF);

        // Loads with lane selection and extension
        rd_word = 32'h12F03456;
        exp_bus(1'b0, 32'h200, 32'd0, 1'b0, 4'b0000);
        exp_done(32'hFFFFFFF0, 1'b1, 1'b0, 2'b00, 3);
        issue(1'b1, 1'b0, B, 32'h202, 32'd0);
        exp_bus(1'b0, 32'h200, 32'd0, 1'b0, 4'b0000);
        exp_done(32'h000000F0, 1'b1, 1'b0, 2'b00, 3);
        issue(1'b1, 1'b0, BU, 32'h202, 32'd0);
        exp_bus(1'b0, 32'h200, 32'd0, 1'b0, 4'b0000);
        exp_done(32'h000012F0, 1'b1, 1'b0, 2'b00, 3);
        issue(1'b1, 1'b0, HU, 32'h202, 32'd0);
        rd_word = 32'h00007F00;
        exp_bus(1'b0, 32'h200, 32'd0, 1'b0, 4'b0000);
        exp_done(32'h0000007F, 1'b1, 1'b0, 2'b00, 3);
        issue(1'b1, 1'b0, B, 32'h201, 32'd0);

        // Stray rvalid in the acceptance cycle must be ignored
        rd_word = 32'h7FFF8001;
        stray = 1'b1;
        exp_bus(1'b0, 32'h200, 32'd0, 1'b0, 4'b0000);
        exp_done(32'hFFFF8001, 1'b1, 1'b0, 2'b00, 3);
        issue(1'b1, 1'b0, H, 32'h200, 32'd0);
        stray = 1'b0;

        // Back-pressure: ready low for 5 cycles, request must hold
        rd_word = 32'hCAFEF00D;
        ready_delay = 5;
        exp_bus(1'b0, 32'h204, 32'd0, 1'b0, 4'b0000);
        exp_done(32'hCAFEF00D, 1'b1, 1'b0, 2'b00, 8);
        issue(1'b1, 1'b0, W, 32'h204, 32'd0);
        ready_delay = 0;

        // Misaligned and illegal: one stall cycle, no bus access
        exp_done(32'd0, 1'b0, 1'b1, 2'b01, 1);
        issue(1'b1, 1'b0, H, 32'h001, 32'd0);
        exp_done(32'd0, 1'b0, 1'b1, 2'b10, 1);
        issue(1'b0, 1'b1, 3'd3, 32'h100, 32'hFFFFFFFF);
        exp_done(32'd0, 1'b0, 1'b1, 2'b01, 1);
        issue(1'b1, 1'b0, W, 32'h102, 32'd0);
        exp_done(32'd0, 1'b0, 1'b1, 2'b10, 1);
        issue(1'b1, 1'b0, 3'd5, 32'h100, 32'd0);
        exp_done(32'd0, 1'b0, 1'b1, 2'b01, 1);
        issue(1'b1, 1'b0, HU, 32'h203, 32'd0);

        // rd_en and wr_en together: store wins
        exp_bus(1'b1, 32'h10C, 32'h55AA55AA, 1'b1, 4'b1111);
        exp_done(32'd0, 1'b0, 1'b0, 2'b00, 2);
        issue(1'b1, 1'b1, W, 32'h10C, 32'h55AA55AA);

        // Timeout on the TIMEOUT=4 instance, then a normal store
        use_b = 1'b1;
        never_ready = 1'b1;
        exp_bus(1'b0, 32'h300, 32'd0, 1'b0, 4'b0000);
        exp_done(32'd0, 1'b1, 1'b1, 2'b11, 5);
        issue(1'b1, 1'b0, W, 32'h300, 32'd0);
        sb_bus.delete();
        never_ready = 1'b0;
        exp_bus(1'b1, 32'h304, 32'h11223344, 1'b1, 4'b1111);
        exp_done(32'd0, 1'b0, 1'b0, 2'b00, 2);
        issue(1'b0, 1'b1, W, 32'h304, 32'h11223344);
        @(posedge clk);
        #1 use_b = 1'b0;

        // Asynchronous reset while waiting for load data
        never_rvalid = 1'b1;
        exp_bus(1'b0, 32'h400, 32'd0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        rd_en = 1'b1; mem_type = W; addr = 32'h400;
        repeat (2) @(posedge clk);
        #3;
        chk("wait_stall", {31'd0, m_stall}, 32'd1);
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        check_reset("async");
        sb_bus.delete();
        sb_done.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        never_rvalid = 1'b0;
        rd_word = 32'h0BADF00D;
        exp_bus(1'b0, 32'h404, 32'd0, 1'b0, 4'b0000);
        exp_done(32'h0BADF00D, 1'b1, 1'b0, 2'b00, 3);
        issue(1'b1, 1'b0, W, 32'h404, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_done_drained", sb_done.size(), 32'd0);
        chk("sb_bus_drained", sb_bus.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
